// File: rtl/vpu_fp_cmp_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FP comparator among NUM_REQ requesters.
// A tag FIFO records grant order so each in-order result is steered back to its owner.
module vpu_fp_cmp_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int OPERAND_WIDTH = 32,
    parameter int TAG_DEPTH     = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    input  logic [NUM_REQ*OPERAND_WIDTH-1:0]   req_a_i,
    input  logic [NUM_REQ*OPERAND_WIDTH-1:0]   req_b_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    output logic                               cmp_valid_o,
    output logic [OPERAND_WIDTH-1:0]           cmp_a_o,
    output logic [OPERAND_WIDTH-1:0]           cmp_b_o,
    input  logic                               cmp_result_valid_i,
    input  logic [3:0]                         cmp_result_i,
    output logic [NUM_REQ-1:0]                 rsp_valid_o,
    output logic [3:0]                         rsp_result_o,
    output logic                               busy_o,
    output logic                               err_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0] r_last_grant;
    logic [IDX_W-1:0] r_tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_err;

    logic                     w_empty;
    logic                     w_full;
    logic                     w_pop;
    logic                     w_can_grant;
    logic                     w_grant_any;
    logic [IDX_W-1:0]         w_grant_idx;
    logic [IDX_W-1:0]         w_head_idx;
    logic [OPERAND_WIDTH-1:0] w_a_slice [NUM_REQ];
    logic [OPERAND_WIDTH-1:0] w_b_slice [NUM_REQ];

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(TAG_DEPTH));
    assign w_head_idx = r_tag_mem[r_rd_ptr];

    // A result with nothing outstanding is a protocol error and must not disturb the FIFO.
    assign w_pop       = rst_n && cmp_result_valid_i && !w_empty;
    assign w_can_grant = rst_n && (!w_full || w_pop);

    // Walk offsets from farthest to nearest so the nearest valid requester is the last write.
    always_comb begin
        int               sum;
        logic [IDX_W-1:0] cand;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        sum         = 0;
        cand        = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            sum = int'(r_last_grant) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            cand = IDX_W'(sum);
            if (req_valid_i[cand]) begin
                w_grant_any = 1'b1;
                w_grant_idx = cand;
            end
        end
        if (!w_can_grant) begin
            w_grant_any = 1'b0;
            w_grant_idx = '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign w_a_slice[gi]   = req_a_i[gi*OPERAND_WIDTH +: OPERAND_WIDTH];
            assign w_b_slice[gi]   = req_b_i[gi*OPERAND_WIDTH +: OPERAND_WIDTH];
            assign req_ready_o[gi] = w_grant_any && (w_grant_idx == IDX_W'(gi));
            assign rsp_valid_o[gi] = w_pop && (w_head_idx == IDX_W'(gi));
        end
    endgenerate

    assign cmp_valid_o  = w_grant_any;
    assign cmp_a_o      = w_grant_any ? w_a_slice[w_grant_idx] : '0;
    assign cmp_b_o      = w_grant_any ? w_b_slice[w_grant_idx] : '0;
    assign rsp_result_o = w_pop ? cmp_result_i : 4'b0000;
    assign busy_o       = rst_n && !w_empty;
    assign err_o        = r_err;

    always_ff @(posedge clk) begin
        if (w_grant_any) begin
            r_tag_mem[r_wr_ptr] <= w_grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_grant_any) begin
                r_wr_ptr     <= r_wr_ptr + PTR_W'(1);
                r_last_grant <= w_grant_idx;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_grant_any, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (cmp_result_valid_i && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vpu_fp_cmp_arbiter.sv
// Directed bench: a latency-2 comparator model drives results; a monitor pops a scoreboard
// of expected responses whenever the arbiter returns one.
module tb_vpu_fp_cmp_arbiter;

    localparam int LAT = 2;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid_i;
    logic [127:0] req_a_i;
    logic [127:0] req_b_i;
    logic [3:0]   req_ready_o;
    logic         cmp_valid_o;
    logic [31:0]  cmp_a_o;
    logic [31:0]  cmp_b_o;
    logic         cmp_result_valid_i;
    logic [3:0]   cmp_result_i;
    logic [3:0]   rsp_valid_o;
    logic [3:0]   rsp_result_o;
    logic         busy_o;
    logic         err_o;

    vpu_fp_cmp_arbiter #(
        .NUM_REQ      (4),
        .OPERAND_WIDTH(32),
        .TAG_DEPTH    (4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid_i       (req_valid_i),
        .req_a_i           (req_a_i),
        .req_b_i           (req_b_i),
        .req_ready_o       (req_ready_o),
        .cmp_valid_o       (cmp_valid_o),
        .cmp_a_o           (cmp_a_o),
        .cmp_b_o           (cmp_b_o),
        .cmp_result_valid_i(cmp_result_valid_i),
        .cmp_result_i      (cmp_result_i),
        .rsp_valid_o       (rsp_valid_o),
        .rsp_result_o      (rsp_result_o),
        .busy_o            (busy_o),
        .err_o             (err_o)
    );

    // Operands per requester: 1.0<2.0, 3.0==3.0, 2.0>1.0, 5.0>4.0
    logic [31:0] a_tbl [4];
    logic [31:0] b_tbl [4];
    logic [3:0]  code_tbl [4];

    typedef struct {
        logic [3:0] oh;
        logic [3:0] code;
        int         cyc;
    } exp_t;

    typedef struct {
        int         due;
        logic [3:0] code;
    } pend_t;

    exp_t  exp_q [$];
    pend_t pend_q [$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit stall = 0;
    bit inj   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Only positive operands are used, so unsigned bit-pattern order equals FP order.
    function automatic logic [3:0] fcmp(input logic [31:0] a, input logic [31:0] b);
        if (a > b)       return 4'b0001;
        else if (a == b) return 4'b0010;
        else             return 4'b0100;
    endfunction

    initial begin
        cmp_result_valid_i = 1'b0;
        cmp_result_i       = 4'b0000;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            cmp_result_valid_i = 1'b0;
            cmp_result_i       = 4'b0000;
            if (inj) begin
                cmp_result_valid_i = 1'b1;
                cmp_result_i       = 4'b0001;
            end else if (!stall && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                cmp_result_valid_i = 1'b1;
                cmp_result_i       = pend_q[0].code;
                void'(pend_q.pop_front());
            end
            @(negedge clk);
            if (cmp_valid_o) begin
                pend_q.push_back('{due: cyc + LAT, code: fcmp(cmp_a_o, cmp_b_o)});
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid_o != 4'b0000) begin
                $display("rsp cyc=%0d req=%b result=%b", cyc, rsp_valid_o, rsp_result_o);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: got req=%b required none", rsp_valid_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_valid", 64'(rsp_valid_o), 64'(e.oh));
                    chk("rsp_result", 64'(rsp_result_o), 64'(e.code));
                    if (e.cyc >= 0) chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    task automatic drive_cycle(input logic [3:0] v, input logic [3:0] exp_ready,
                               input bit push_rsp, input bit chk_lat);
        int idx;
        @(posedge clk);
        #1;
        req_valid_i = v;
        @(negedge clk);
        chk("req_ready", 64'(req_ready_o), 64'(exp_ready));
        if (exp_ready != 4'b0000) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (exp_ready[i]) idx = i;
            $display("grant cyc=%0d valid=%b ready=%b", cyc, v, req_ready_o);
            chk("cmp_valid", 64'(cmp_valid_o), 64'd1);
            chk("cmp_a", 64'(cmp_a_o), 64'(a_tbl[idx]));
            chk("cmp_b", 64'(cmp_b_o), 64'(b_tbl[idx]));
            if (push_rsp) begin
                exp_q.push_back('{oh: exp_ready, code: code_tbl[idx],
                                  cyc: chk_lat ? cyc + LAT : -1});
            end
        end else begin
            chk("cmp_valid_idle", 64'(cmp_valid_o), 64'd0);
            chk("cmp_a_idle", 64'(cmp_a_o), 64'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(4'b0000, 4'b0000, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] seq_a [5];
        a_tbl    = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'h40A00000};
        b_tbl    = '{32'h40000000, 32'h40400000, 32'h3F800000, 32'h40800000};
        code_tbl = '{4'b0100, 4'b0010, 4'b0001, 4'b0001};
        seq_a    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req_a_i  = {a_tbl[3], a_tbl[2], a_tbl[1], a_tbl[0]};
        req_b_i  = {b_tbl[3], b_tbl[2], b_tbl[1], b_tbl[0]};
        rst_n       = 1'b0;
        req_valid_i = 4'b0000;

        // Outputs held quiet during reset even with every requester asking
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1 req_valid_i = 4'b1111;
        @(negedge clk);
        chk("rst_ready", 64'(req_ready_o), 64'd0);
        chk("rst_cmp_valid", 64'(cmp_valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_rsp_result", 64'(rsp_result_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        req_valid_i = 4'b0000;

        // All requesters held: grants rotate 0,1,2,3,0; responses two cycles later
        for (int i = 0; i < 5; i++) drive_cycle(4'b1111, seq_a[i], 1'b1, 1'b1);
        idle(4);
        chk("busy_drained_a", 64'(busy_o), 64'd0);

        // Only requester 2: 2.0 > 1.0
        drive_cycle(4'b0100, 4'b0100, 1'b1, 1'b1);
        idle(3);

        // Requester 1 loses to 0 and drops; pointer must stay at 0 so 1 wins next
        drive_cycle(4'b1000, 4'b1000, 1'b1, 1'b1);
        drive_cycle(4'b0011, 4'b0001, 1'b1, 1'b1);
        drive_cycle(4'b0000, 4'b0000, 1'b0, 1'b0);
        drive_cycle(4'b0011, 4'b0010, 1'b1, 1'b1);
        idle(4);

        // Stalled comparator: four grants fill the FIFO, then all ready low
        stall = 1'b1;
        drive_cycle(4'b1111, 4'b0100, 1'b1, 1'b0);
        drive_cycle(4'b1111, 4'b1000, 1'b1, 1'b0);
        drive_cycle(4'b1111, 4'b0001, 1'b1, 1'b0);
        drive_cycle(4'b1111, 4'b0010, 1'b1, 1'b0);
        drive_cycle(4'b1111, 4'b0000, 1'b0, 1'b0);
        drive_cycle(4'b1111, 4'b0000, 1'b0, 1'b0);
        chk("busy_full", 64'(busy_o), 64'd1);
        stall = 1'b0;
        drive_cycle(4'b1111, 4'b0100, 1'b1, 1'b0);
        stall = 1'b1;
        drive_cycle(4'b1111, 4'b0000, 1'b0, 1'b0);
        stall = 1'b0;
        idle(7);
        chk("busy_drained_d", 64'(busy_o), 64'd0);

        // Result with nothing in flight flags a sticky error
        chk("err_before", 64'(err_o), 64'd0);
        inj = 1'b1;
        drive_cycle(4'b0000, 4'b0000, 1'b0, 1'b0);
        chk("err_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("err_same_cycle", 64'(err_o), 64'd0);
        inj = 1'b0;
        idle(1);
        chk("err_set", 64'(err_o), 64'd1);
        idle(1);
        chk("err_sticky", 64'(err_o), 64'd1);

        // Two in flight, one-cycle reset: tags dropped, late result errors, requester 0 next
        drive_cycle(4'b1111, 4'b1000, 1'b0, 1'b0);
        drive_cycle(4'b1111, 4'b0001, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        req_valid_i = 4'b1111;
        @(negedge clk);
        chk("mid_rst_ready", 64'(req_ready_o), 64'd0);
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        chk("mid_rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("mid_rst_rsp_result", 64'(rsp_result_o), 64'd0);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        req_valid_i = 4'b0000;
        @(negedge clk);
        chk("post_rst_busy", 64'(busy_o), 64'd0);
        chk("post_rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("post_rst_err_cleared", 64'(err_o), 64'd0);
        drive_cycle(4'b1111, 4'b0001, 1'b1, 1'b1);
        chk("late_result_err", 64'(err_o), 64'd1);
        idle(4);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("final_err_cleared", 64'(err_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vpu_fp_cmp_arbiter.md
VPU_FP_CMP_ARBITER -- requirements
Module: vpu_fp_cmp_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of requesters sharing one floating-point comparator.
REQ-002 The block SHALL have parameter OPERAND_WIDTH, default 32, width of each FP operand.
REQ-003 The block SHALL have parameter TAG_DEPTH, default 4, maximum in-flight comparisons, a power of two and at least 2.
REQ-004 The block SHALL have port clk  input  1  clock, all logic on the rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port req_valid_i  input  NUM_REQ  per-requester compare request.
REQ-007 The block SHALL have port req_a_i  input  NUM_REQ*OPERAND_WIDTH  operand A, requester i in slice i.
REQ-008 The block SHALL have port req_b_i  input  NUM_REQ*OPERAND_WIDTH  operand B, requester i in slice i.
REQ-009 The block SHALL have port req_ready_o  output  NUM_REQ  one-hot grant, request i accepted when valid and ready are both high.
REQ-010 The block SHALL have port cmp_valid_o  output  1  issue strobe to the comparator, driving both its A and B tvalid inputs.
REQ-011 The block SHALL have ports cmp_a_o and cmp_b_o  output  OPERAND_WIDTH each  operands to the comparator.
REQ-012 The block SHALL have port cmp_result_valid_i  input  1  comparator result valid.
REQ-013 The block SHALL have port cmp_result_i  input  4  comparator result code (4'b0001 means A greater than B).
REQ-014 The block SHALL have port rsp_valid_o  output  NUM_REQ  one-hot result return to the owning requester.
REQ-015 The block SHALL have port rsp_result_o  output  4  result code, broadcast to all requesters.
REQ-016 The block SHALL have port busy_o  output  1  high while any comparison is in flight.
REQ-017 The block SHALL have port err_o  output  1  sticky protocol error flag.

Function
REQ-018 Grant SHALL be round-robin: search starts at requester (last_grant+1) mod NUM_REQ, and the first requester with valid high wins.
REQ-019 At most one grant SHALL occur per cycle; req_ready_o SHALL be combinational from req_valid_i, the round-robin pointer and FIFO state.
REQ-020 last_grant SHALL update only in a cycle with a grant; after reset last_grant = NUM_REQ-1, so requester 0 has first priority.
REQ-021 On grant, cmp_valid_o SHALL be 1 in the same cycle, and cmp_a_o/cmp_b_o SHALL equal the granted requester's slices.
REQ-022 With no grant, cmp_valid_o, cmp_a_o and cmp_b_o SHALL be 0.
REQ-023 Each grant SHALL push the granted index into a tag FIFO of depth TAG_DEPTH.
REQ-024 Each cmp_result_valid_i SHALL pop the FIFO head.
REQ-025 rsp_valid_o SHALL be the one-hot of the popped index, and rsp_result_o SHALL equal cmp_result_i in the same cycle (combinational, no added latency).
REQ-026 rsp_result_o SHALL be 0 when no result is valid.
REQ-027 Results SHALL return in issue order, since the comparator has fixed latency; there is no response backpressure.
REQ-028 FIFO full with no pop in the same cycle SHALL force req_ready_o to all zero.
REQ-029 FIFO full with a pop in the same cycle SHALL allow a grant (simultaneous push and pop).
REQ-030 Simultaneous push and pop SHALL leave the occupancy count unchanged; read and write pointers SHALL wrap modulo TAG_DEPTH.
REQ-031 busy_o SHALL equal (occupancy != 0).
REQ-032 A cmp_result_valid_i with the FIFO empty SHALL set err_o, which then stays 1 until reset; rsp_valid_o SHALL stay 0 and the FIFO state SHALL be unchanged.
REQ-033 Deasserting req_valid_i without a grant SHALL be legal and SHALL NOT move the pointer.

Reset
REQ-034 When rst_n=0 at a clock edge, occupancy, FIFO pointers and err_o SHALL clear to 0, and last_grant SHALL be set to NUM_REQ-1.
REQ-035 During reset req_ready_o, cmp_valid_o, rsp_valid_o, rsp_result_o and busy_o SHALL read 0.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight tags; results arriving after reset SHALL set err_o per REQ-032.

Verification
REQ-037 Scenario: req_valid_i=4'b1111 held, comparator latency 2 -> grants 0,1,2,3,0 on consecutive cycles, and rsp_valid_o one-hots follow two cycles later in the same order.
REQ-038 Scenario: only req 2 valid, A=0x40000000 (2.0), B=0x3F800000 (1.0) -> req_ready_o=4'b0100, and later rsp_valid_o=4'b0100 with rsp_result_o=4'b0001.
REQ-039 Scenario: stall comparator results with TAG_DEPTH=4 and 4 grants issued -> req_ready_o=0 while full; a grant reoccurs in the cycle of the first result, and occupancy stays 4.
REQ-040 Scenario: cmp_result_valid_i=1 with the FIFO empty -> err_o=1 from the next cycle onward, and rsp_valid_o=0.
REQ-041 Scenario: 2 comparisons in flight, then rst_n=0 for 1 cycle -> busy_o=0, and the next grant goes to requester 0.
REQ-042 Scenario: req 1 valid for 1 cycle without grant (req 0 wins), then req 1 drops -> no response to req 1, and the pointer stays at 0.
